// File: rtl/mcu_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mcu_scheduler : walks a planar 4:4:4 frame in MCU order and feeds the JPEG encoder
// Rev 1.0
// ---------------------------------------------------------------------------
module mcu_scheduler #(
   parameter int         ADDR_W    = 16,
   parameter int         DIM_W     = 8,
   parameter int         BLOCK_GAP = 0,
   parameter logic [1:0] Y_CODE    = 2'b10,
   parameter logic [1:0] CB_CODE   = 2'b00,
   parameter logic [1:0] CR_CODE   = 2'b01
) (
   input  logic              I_clk,
   input  logic              I_rst,
   input  logic              I_start,
   input  logic [DIM_W-1:0]  I_width_blocks,
   input  logic [DIM_W-1:0]  I_height_blocks,
   input  logic              I_hold,
   output logic              O_rd_en,
   output logic [1:0]        O_rd_plane,
   output logic [ADDR_W-1:0] O_rd_addr,
   input  logic [7:0]        I_rd_data,
   output logic              O_enc_en,
   output logic              O_valid_data,
   output logic [7:0]        O_data,
   output logic [1:0]        O_ycbcr,
   output logic              O_end_of_img,
   output logic              O_busy,
   output logic              O_done
);
   localparam int c_gap_w = (BLOCK_GAP > 1) ? $clog2(BLOCK_GAP) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_GAP   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic [DIM_W-1:0]   w_q, h_q, bx_q, by_q;
   logic [1:0]         k_q;
   logic [2:0]         r_q, c_q;
   logic [c_gap_w-1:0] gap_q;
   logic               last_q, eoi_seen_q;

   logic               ret_vld_q, ret_eoi_q;
   logic [1:0]         ret_code_q;
   logic               skid_vld_q, skid_eoi_q;
   logic [7:0]         skid_data_q;
   logic [1:0]         skid_code_q;
   logic               out_vld_q, out_eoi_q;
   logic [7:0]         out_data_q;
   logic [1:0]         out_code_q;

   logic               w_dims_ok, w_issue, w_blk_end, w_mcu_end, w_bx_end, w_last_rd, w_gap_end;
   logic [1:0]         w_code;

   assign w_dims_ok = (I_width_blocks != '0) && (I_height_blocks != '0);
   assign w_issue   = (state_q == S_RUN) && !I_hold && !skid_vld_q;
   assign w_blk_end = (r_q == 3'd7) && (c_q == 3'd7);
   assign w_mcu_end = w_blk_end && (k_q == 2'd2);
   assign w_bx_end  = (bx_q == w_q - DIM_W'(1));
   assign w_last_rd = w_mcu_end && w_bx_end && (by_q == h_q - DIM_W'(1));
   assign w_gap_end = (gap_q == c_gap_w'(BLOCK_GAP - 1));

   always_comb begin
      w_code = CR_CODE;
      case (k_q)
         2'd0:    w_code = Y_CODE;
         2'd1:    w_code = CB_CODE;
         default: w_code = CR_CODE;
      endcase
   end

   // Address arithmetic is modulo 2^ADDR_W, so the product is formed directly at that width.
   assign O_rd_en      = w_issue;
   assign O_rd_plane   = k_q;
   assign O_rd_addr    = ADDR_W'({by_q, r_q}) * ADDR_W'({w_q, 3'b000}) + ADDR_W'({bx_q, c_q});
   assign O_enc_en     = !I_hold;
   assign O_valid_data = out_vld_q;
   assign O_data       = out_data_q;
   assign O_ycbcr      = out_code_q;
   assign O_end_of_img = out_eoi_q;
   assign O_busy       = (state_q != S_IDLE);
   assign O_done       = (state_q == S_DONE);

   always_ff @(posedge I_clk) begin
      if (I_rst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (I_start) state_d = w_dims_ok ? S_RUN : S_DONE;
         S_RUN: begin
            if (w_issue && w_blk_end) begin
               if (BLOCK_GAP > 0)  state_d = S_GAP;
               else if (w_last_rd) state_d = S_DRAIN;
            end
         end
         S_GAP:   if (!I_hold && w_gap_end) state_d = last_q ? S_DRAIN : S_RUN;
         S_DRAIN: if (eoi_seen_q) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Scan counters: column fastest, then row, component, block x, block y.
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         w_q <= '0; h_q <= '0; bx_q <= '0; by_q <= '0;
         k_q <= '0; r_q <= '0; c_q <= '0; gap_q <= '0;
         last_q <= 1'b0; eoi_seen_q <= 1'b0;
      end else begin
         if (state_q == S_IDLE && I_start) begin
            w_q <= I_width_blocks; h_q <= I_height_blocks;
            bx_q <= '0; by_q <= '0; k_q <= '0; r_q <= '0; c_q <= '0;
            last_q <= 1'b0; eoi_seen_q <= 1'b0;
         end
         if (w_issue) begin
            c_q <= c_q + 3'd1;
            if (c_q == 3'd7) begin
               r_q <= r_q + 3'd1;
               if (r_q == 3'd7) begin
                  if (k_q == 2'd2) begin
                     k_q <= 2'd0;
                     if (w_bx_end) begin
                        bx_q <= '0;
                        by_q <= by_q + DIM_W'(1);
                     end else begin
                        bx_q <= bx_q + DIM_W'(1);
                     end
                  end else begin
                     k_q <= k_q + 2'd1;
                  end
               end
            end
            if (w_last_rd) last_q <= 1'b1;
         end
         // Sticky so a trailing gap cannot hide the consumption of the last sample.
         if (out_vld_q && out_eoi_q && !I_hold) eoi_seen_q <= 1'b1;
         if (state_q == S_GAP && !I_hold) gap_q <= w_gap_end ? '0 : gap_q + c_gap_w'(1);
      end
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         ret_vld_q <= 1'b0; ret_eoi_q <= 1'b0; ret_code_q <= '0;
         skid_vld_q <= 1'b0; skid_eoi_q <= 1'b0; skid_data_q <= '0; skid_code_q <= '0;
         out_vld_q <= 1'b0; out_eoi_q <= 1'b0; out_data_q <= '0; out_code_q <= '0;
      end else begin
         ret_vld_q  <= w_issue;
         ret_eoi_q  <= w_issue && w_last_rd;
         ret_code_q <= w_code;
         if (I_hold) begin
            if (ret_vld_q) begin
               skid_vld_q  <= 1'b1;
               skid_data_q <= I_rd_data;
               skid_code_q <= ret_code_q;
               skid_eoi_q  <= ret_eoi_q;
            end
         end else if (skid_vld_q) begin
            out_vld_q  <= 1'b1;
            out_data_q <= skid_data_q;
            out_code_q <= skid_code_q;
            out_eoi_q  <= skid_eoi_q;
            skid_vld_q <= 1'b0;
         end else if (ret_vld_q) begin
            out_vld_q  <= 1'b1;
            out_data_q <= I_rd_data;
            out_code_q <= ret_code_q;
            out_eoi_q  <= ret_eoi_q;
         end else begin
            out_vld_q <= 1'b0;
            out_eoi_q <= 1'b0;
         end
      end
   end

   a_skid_no_overflow: assert property (@(posedge I_clk) disable iff (I_rst) !(ret_vld_q && skid_vld_q));

endmodule
`default_nettype wire

// File: tb/tb_mcu_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mcu_scheduler : directed checks of MCU scan order, hold/skid, block gaps, zero size, reset abort
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mcu_scheduler;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1, hold = 1'b0, hold_b = 1'b0;
   logic       start_a = 1'b0, start_b = 1'b0;
   logic [7:0] wb_a = '0, hb_a = '0, wb_b = '0, hb_b = '0;

   logic        rd_en_a, enc_en_a, vld_a, eoi_a, busy_a, done_a;
   logic [1:0]  plane_a, ycbcr_a;
   logic [15:0] addr_a;
   logic [7:0]  rdata_a = '0, data_a;
   logic        rd_en_b, enc_en_b, vld_b, eoi_b, busy_b, done_b;
   logic [1:0]  plane_b, ycbcr_b;
   logic [15:0] addr_b;
   logic [7:0]  rdata_b = '0, data_b;

   mcu_scheduler #(.ADDR_W(16), .DIM_W(8), .BLOCK_GAP(0)) u_dut_a (
      .I_clk(clk), .I_rst(rst), .I_start(start_a), .I_width_blocks(wb_a), .I_height_blocks(hb_a),
      .I_hold(hold), .O_rd_en(rd_en_a), .O_rd_plane(plane_a), .O_rd_addr(addr_a), .I_rd_data(rdata_a),
      .O_enc_en(enc_en_a), .O_valid_data(vld_a), .O_data(data_a), .O_ycbcr(ycbcr_a),
      .O_end_of_img(eoi_a), .O_busy(busy_a), .O_done(done_a));

   mcu_scheduler #(.ADDR_W(16), .DIM_W(8), .BLOCK_GAP(4)) u_dut_b (
      .I_clk(clk), .I_rst(rst), .I_start(start_b), .I_width_blocks(wb_b), .I_height_blocks(hb_b),
      .I_hold(hold_b), .O_rd_en(rd_en_b), .O_rd_plane(plane_b), .O_rd_addr(addr_b), .I_rd_data(rdata_b),
      .O_enc_en(enc_en_b), .O_valid_data(vld_b), .O_data(data_b), .O_ycbcr(ycbcr_b),
      .O_end_of_img(eoi_b), .O_busy(busy_b), .O_done(done_b));

   function automatic logic [7:0] memf(input logic [1:0] p, input logic [15:0] a);
      logic [15:0] t;
      t = a * 16'd5 + (a >> 8) * 16'd3 + {14'd0, p} * 16'd85;
      return t[7:0];
   endfunction

   always @(posedge clk) if (rd_en_a) rdata_a <= memf(plane_a, addr_a);
   always @(posedge clk) if (rd_en_b) rdata_b <= memf(plane_b, addr_b);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          rd_cyc_a[$], val_cyc_a[$], done_cyc_a[$], rd_cyc_b[$], done_cyc_b[$];
   logic [17:0] rd_pa_a[$], out_a[$], out_b[$];
   int          viol_a = 0, eoi_cnt_a = 0, busy_fall_a = -1;
   logic        busy_prev_a = 1'b0;

   always @(negedge clk) begin
      if (rd_en_a) begin
         rd_cyc_a.push_back(cyc);
         rd_pa_a.push_back({plane_a, addr_a});
         if (hold) viol_a++;
      end
      if (vld_a && enc_en_a) begin
         out_a.push_back({7'd0, eoi_a, ycbcr_a, data_a});
         val_cyc_a.push_back(cyc);
      end
      if (eoi_a && enc_en_a) eoi_cnt_a++;
      if (done_a) done_cyc_a.push_back(cyc);
      if (busy_prev_a && !busy_a) busy_fall_a = cyc;
      busy_prev_a = busy_a;
      if (rd_en_b) rd_cyc_b.push_back(cyc);
      if (vld_b && enc_en_b) out_b.push_back({7'd0, eoi_b, ycbcr_b, data_b});
      if (done_b) done_cyc_b.push_back(cyc);
   end

   int n_cmp = 0, n_bad = 0;
   logic [17:0] exp_pa[$], exp_out[$];

   // Independent reference: nested MCU scan producing expected reads and encoder stream.
   function automatic void build_exp(input int w, input int h);
      logic [15:0] a;
      logic [1:0]  code;
      logic        last;
      exp_pa.delete();
      exp_out.delete();
      for (int by = 0; by < h; by++)
         for (int bx = 0; bx < w; bx++)
            for (int k = 0; k < 3; k++)
               for (int r = 0; r < 8; r++)
                  for (int c = 0; c < 8; c++) begin
                     a    = 16'((by * 8 + r) * w * 8 + bx * 8 + c);
                     code = (k == 0) ? 2'b10 : (k == 1) ? 2'b00 : 2'b01;
                     last = (by == h - 1) && (bx == w - 1) && (k == 2) && (r == 7) && (c == 7);
                     exp_pa.push_back({2'(k), a});
                     exp_out.push_back({7'd0, last, code, memf(2'(k), a)});
                  end
   endfunction

   function automatic int qdiff(input logic [17:0] got[$], input logic [17:0] want[$]);
      if (got.size() != want.size()) return -2;
      foreach (want[i]) if (got[i] !== want[i]) return i;
      return -1;
   endfunction

   function automatic int q_at(input int q[$], input int i);
      return (i >= 0 && i < q.size()) ? q[i] : -999;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      rd_cyc_a.delete(); val_cyc_a.delete(); done_cyc_a.delete(); rd_pa_a.delete(); out_a.delete();
      rd_cyc_b.delete(); done_cyc_b.delete(); out_b.delete();
      viol_a = 0; eoi_cnt_a = 0; busy_fall_a = -1;
   endtask

   task automatic start_frame_a(input int w, input int h, output int s);
      wb_a = 8'(w); hb_a = 8'(h); start_a = 1'b1; s = cyc;
      tick();
      start_a = 1'b0;
   endtask

   task automatic wait_done_a(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         if (done_cyc_a.size() != 0) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; hold = 1'b0;
      tick(); tick();
      n_cmp++;
      if ({rd_en_a, vld_a, data_a, ycbcr_a, eoi_a, busy_a, done_a} !== 15'd0) begin
         n_bad++; $display("FAIL reset_outputs: got %h want 0", {rd_en_a, vld_a, data_a, ycbcr_a, eoi_a, busy_a, done_a});
      end
      n_cmp++;
      if (enc_en_a !== 1'b1) begin n_bad++; $display("FAIL reset_enc_en: got %b want 1", enc_en_a); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_block();
      int s, d; bit ok;
      clear_mon(); build_exp(1, 1);
      start_frame_a(1, 1, s);
      wait_done_a(400, ok);
      tick(); tick();
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL 1x1_done_seen: got 0 want 1"); end
      d = qdiff(rd_pa_a, exp_pa);
      n_cmp++; if (d != -1) begin n_bad++; $display("FAIL 1x1_read_seq: first bad index %0d want -1 (len %0d want %0d)", d, rd_pa_a.size(), exp_pa.size()); end
      d = qdiff(out_a, exp_out);
      n_cmp++; if (d != -1) begin n_bad++; $display("FAIL 1x1_sample_seq: first bad index %0d want -1 (len %0d want %0d)", d, out_a.size(), exp_out.size()); end
      n_cmp++; if (q_at(rd_cyc_a, 0) != s + 1) begin n_bad++; $display("FAIL 1x1_first_read_cycle: got %0d want %0d", q_at(rd_cyc_a, 0), s + 1); end
      n_cmp++; if (q_at(rd_cyc_a, 191) - q_at(rd_cyc_a, 0) != 191) begin n_bad++; $display("FAIL 1x1_back_to_back: got span %0d want 191", q_at(rd_cyc_a, 191) - q_at(rd_cyc_a, 0)); end
      n_cmp++; if (q_at(val_cyc_a, 0) != s + 3) begin n_bad++; $display("FAIL 1x1_latency: got %0d want %0d", q_at(val_cyc_a, 0), s + 3); end
      n_cmp++; if (q_at(done_cyc_a, 0) != q_at(val_cyc_a, val_cyc_a.size() - 1) + 2) begin
         n_bad++; $display("FAIL 1x1_done_cycle: got %0d want %0d", q_at(done_cyc_a, 0), q_at(val_cyc_a, val_cyc_a.size() - 1) + 2);
      end
      n_cmp++; if (done_cyc_a.size() != 1) begin n_bad++; $display("FAIL 1x1_done_count: got %0d want 1", done_cyc_a.size()); end
      n_cmp++; if (busy_fall_a != q_at(done_cyc_a, 0) + 1) begin n_bad++; $display("FAIL 1x1_busy_fall: got %0d want %0d", busy_fall_a, q_at(done_cyc_a, 0) + 1); end
   endtask

   task automatic test_two_by_two();
      int s, d; bit ok;
      clear_mon(); build_exp(2, 2);
      start_frame_a(2, 2, s);
      wait_done_a(1200, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL 2x2_done_seen: got 0 want 1"); end
      n_cmp++; if ((rd_pa_a.size() > 192 ? rd_pa_a[192] : 18'h3FFFF) !== {2'd0, 16'd8}) begin
         n_bad++; $display("FAIL 2x2_mcu1_y_addr: got %h want %h", rd_pa_a.size() > 192 ? rd_pa_a[192] : 18'h3FFFF, {2'd0, 16'd8});
      end
      n_cmp++; if ((rd_pa_a.size() > 392 ? rd_pa_a[392] : 18'h3FFFF) !== {2'd0, 16'd144}) begin
         n_bad++; $display("FAIL 2x2_mcu2_row1_addr: got %h want %h", rd_pa_a.size() > 392 ? rd_pa_a[392] : 18'h3FFFF, {2'd0, 16'd144});
      end
      d = qdiff(rd_pa_a, exp_pa);
      n_cmp++; if (d != -1) begin n_bad++; $display("FAIL 2x2_read_seq: first bad index %0d want -1", d); end
      d = qdiff(out_a, exp_out);
      n_cmp++; if (d != -1) begin n_bad++; $display("FAIL 2x2_sample_seq: first bad index %0d want -1", d); end
      n_cmp++; if (q_at(rd_cyc_a, 767) - q_at(rd_cyc_a, 0) != 767) begin n_bad++; $display("FAIL 2x2_back_to_back: got span %0d want 767", q_at(rd_cyc_a, 767) - q_at(rd_cyc_a, 0)); end
   endtask

   task automatic test_hold_release();
      int s, d; bit ok;
      clear_mon(); build_exp(1, 1);
      start_frame_a(1, 1, s);
      repeat (10) tick();
      hold = 1'b1;
      repeat (3) tick();
      hold = 1'b0;
      wait_done_a(400, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL hold_rel_done_seen: got 0 want 1"); end
      n_cmp++; if (q_at(rd_cyc_a, 10) - q_at(rd_cyc_a, 9) != 5) begin n_bad++; $display("FAIL hold_rel_resume: got gap %0d want 5", q_at(rd_cyc_a, 10) - q_at(rd_cyc_a, 9)); end
      d = qdiff(out_a, exp_out);
      n_cmp++; if (d != -1) begin n_bad++; $display("FAIL hold_rel_sample_seq: first bad index %0d want -1", d); end
   endtask

   task automatic test_random_hold();
      int s, d; bit ok;
      clear_mon(); build_exp(3, 2);
      start_frame_a(3, 2, s);
      for (int i = 0; i < 6000 && done_cyc_a.size() == 0; i++) begin
         hold = ($urandom_range(0, 99) < 30);
         tick();
      end
      hold = 1'b0;
      ok = (done_cyc_a.size() != 0);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rnd_hold_done_seen: got 0 want 1"); end
      d = qdiff(rd_pa_a, exp_pa);
      n_cmp++; if (d != -1) begin n_bad++; $display("FAIL rnd_hold_read_seq: first bad index %0d want -1", d); end
      d = qdiff(out_a, exp_out);
      n_cmp++; if (d != -1) begin n_bad++; $display("FAIL rnd_hold_sample_seq: first bad index %0d want -1 (len %0d want %0d)", d, out_a.size(), exp_out.size()); end
      n_cmp++; if (viol_a != 0) begin n_bad++; $display("FAIL rnd_hold_rd_while_hold: got %0d want 0", viol_a); end
      tick(); tick();
   endtask

   task automatic test_block_gap();
      int s, d, bad;
      clear_mon(); build_exp(2, 1);
      wb_b = 8'd2; hb_b = 8'd1; start_b = 1'b1; s = cyc;
      tick();
      start_b = 1'b0;
      for (int i = 0; i < 2000 && done_cyc_b.size() == 0; i++) tick();
      n_cmp++; if (done_cyc_b.size() != 1) begin n_bad++; $display("FAIL gap_done_count: got %0d want 1", done_cyc_b.size()); end
      n_cmp++; if (rd_cyc_b.size() != 384) begin n_bad++; $display("FAIL gap_read_count: got %0d want 384", rd_cyc_b.size()); end
      bad = 0;
      for (int j = 0; j < 383; j++)
         if (q_at(rd_cyc_b, j + 1) - q_at(rd_cyc_b, j) != (((j + 1) % 64 == 0) ? 5 : 1)) bad++;
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL gap_spacing: got %0d bad intervals want 0", bad); end
      n_cmp++; if (q_at(done_cyc_b, 0) != q_at(rd_cyc_b, 383) + 6) begin n_bad++; $display("FAIL gap_done_cycle: got %0d want %0d", q_at(done_cyc_b, 0), q_at(rd_cyc_b, 383) + 6); end
      d = qdiff(out_b, exp_out);
      n_cmp++; if (d != -1) begin n_bad++; $display("FAIL gap_sample_seq: first bad index %0d want -1", d); end
      tick(); tick();
   endtask

   task automatic test_zero_and_busy_start();
      int s, s2, d; bit ok;
      clear_mon();
      start_frame_a(0, 3, s);
      repeat (4) tick();
      n_cmp++; if (q_at(done_cyc_a, 0) != s + 1 || done_cyc_a.size() != 1) begin
         n_bad++; $display("FAIL zero_dim_done: got cycle %0d (count %0d) want %0d (count 1)", q_at(done_cyc_a, 0), done_cyc_a.size(), s + 1);
      end
      n_cmp++; if (rd_cyc_a.size() != 0) begin n_bad++; $display("FAIL zero_dim_reads: got %0d want 0", rd_cyc_a.size()); end
      clear_mon(); build_exp(1, 1);
      start_frame_a(1, 1, s);
      repeat (5) tick();
      start_frame_a(2, 2, s2);
      wait_done_a(400, ok);
      repeat (4) tick();
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL busy_start_done_seen: got 0 want 1"); end
      d = qdiff(rd_pa_a, exp_pa);
      n_cmp++; if (d != -1) begin n_bad++; $display("FAIL busy_start_ignored: first bad index %0d want -1 (len %0d want 192)", d, rd_pa_a.size()); end
   endtask

   task automatic test_reset_mid_frame();
      int s, d; bit ok;
      clear_mon();
      start_frame_a(2, 2, s);
      repeat (100) tick();
      rst = 1'b1;
      tick();
      n_cmp++;
      if ({rd_en_a, vld_a, data_a, ycbcr_a, eoi_a, busy_a, done_a} !== 15'd0) begin
         n_bad++; $display("FAIL midreset_outputs: got %h want 0", {rd_en_a, vld_a, data_a, ycbcr_a, eoi_a, busy_a, done_a});
      end
      rst = 1'b0;
      clear_mon();
      repeat (30) tick();
      n_cmp++; if (done_cyc_a.size() != 0 || eoi_cnt_a != 0 || rd_cyc_a.size() != 0) begin
         n_bad++; $display("FAIL midreset_abort: got done %0d eoi %0d reads %0d want 0 0 0", done_cyc_a.size(), eoi_cnt_a, rd_cyc_a.size());
      end
      clear_mon(); build_exp(1, 1);
      start_frame_a(1, 1, s);
      wait_done_a(400, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL midreset_restart_done: got 0 want 1"); end
      d = qdiff(out_a, exp_out);
      n_cmp++; if (d != -1) begin n_bad++; $display("FAIL midreset_restart_seq: first bad index %0d want -1", d); end
   endtask

   initial begin
      test_reset();
      test_single_block();
      test_two_by_two();
      test_hold_release();
      test_random_hold();
      test_block_gap();
      test_zero_and_busy_start();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/mcu_scheduler.md
# mcu_scheduler

Frame-level sequencer that feeds the JPEG encoder pipeline from a planar 4:4:4 frame buffer. On a start command it walks the image in MCU order (one 8x8 MCU = Y block, Cb block, Cr block) and raster order inside each block. For each sample it issues a read to the frame memory and presents the returned sample to the encoder together with the `I_valid_data`, `I_ycbcr` and `I_end_of_img` qualifiers and the encoder enable. It also absorbs downstream hold through a one-entry skid register.

## Interface
Parameters:
- `ADDR_W`, 16: frame-memory word address width (per plane).
- `DIM_W`, 8: width of the block-count configuration inputs.
- `BLOCK_GAP`, 0: idle cycles inserted after every 64-sample block, including the last one.
- `Y_CODE`, 2'b10: `O_ycbcr` tag for luma samples.
- `CB_CODE`, 2'b00: `O_ycbcr` tag for Cb samples.
- `CR_CODE`, 2'b01: `O_ycbcr` tag for Cr samples.

Ports:
- `I_clk` in 1: single clock. All logic is on the rising edge.
- `I_rst` in 1: synchronous, active-high reset.
- `I_start` in 1: one-cycle frame start. Ignored while `O_busy`=1.
- `I_width_blocks` in DIM_W: image width in 8-pixel blocks. Latched on an accepted start.
- `I_height_blocks` in DIM_W: image height in 8-line blocks. Latched on an accepted start.
- `I_hold` in 1: downstream stall. While high the encoder is frozen and no read is issued.
- `O_rd_en` in→out 1: memory read strobe.
- `O_rd_plane` out 2: plane of the read (0 = Y, 1 = Cb, 2 = Cr).
- `O_rd_addr` out ADDR_W: read address within the plane.
- `I_rd_data` in 8: read data, valid exactly 1 cycle after `O_rd_en`.
- `O_enc_en` out 1: encoder enable, equal to `!I_hold` (combinational).
- `O_valid_data` out 1: registered sample-valid to the encoder.
- `O_data` out 8: registered sample.
- `O_ycbcr` out 2: registered component tag of `O_data`.
- `O_end_of_img` out 1: high with the final Cr sample of the frame.
- `O_busy` out 1: high from the accepted start until `O_done`.
- `O_done` out 1: one-cycle pulse at frame completion.

## Operation
- **States:** IDLE, RUN, GAP, DRAIN, DONE.
- **IDLE → RUN:** on `I_start` with both dimensions nonzero. The dimensions are latched and all counters are cleared.
- **IDLE → DONE:** on `I_start` with either dimension zero. No reads are issued.
- **Counters:**
  - column `c` 0..7 increments fastest, then row `r` 0..7.
  - component `k` (Y, Cb, Cr) advances after each block.
  - block x `bx` advances after each MCU, then block y `by`.
- **Address:** `(by*8 + r) * (W*8) + bx*8 + c`, truncated to ADDR_W. `O_rd_plane` = `k`.
- **Issue rule:** a read is issued in RUN only when `I_hold`=0 and the skid register is empty. Counters advance only on an issue.
- **RUN → GAP:** after the 64th read of a block, when BLOCK_GAP > 0. GAP counts BLOCK_GAP cycles, with `I_hold` pausing the count, then returns to RUN.
- **RUN (or GAP) → DRAIN:** after the last read of the frame (`k`=Cr, `bx`=W-1, `by`=H-1, `r`=`c`=7).
- **DRAIN → DONE:** once the last sample has been loaded into the output register with `I_hold`=0.
- **DONE:** pulses `O_done` for one cycle, then goes to IDLE.
- **Tag pipeline:** each read carries its tag (component code, end-of-image flag). The tag travels with the returned data through the skid and output registers.
- **Return with `I_hold`=0:**
  - if the skid is full, the output register loads the skid entry and the skid empties;
  - else if read data is returning, the output register loads it with valid = 1;
  - else valid = 0.
- **Return with `I_hold`=1:** the output register is frozen, and returning data is written into the skid. Skid-full plus a simultaneous return cannot occur because issue is blocked while the skid is full. An assertion checks this.
- **`O_valid_data` meaning:** it is meaningful only when `O_enc_en`=1. The encoder ignores all inputs while held.
- **Reset:**
  - all registered outputs = 0, state IDLE, skid empty, counters 0.
  - A reset during a frame aborts it: no `O_done` and no `O_end_of_img`.

## Timing
- Accepted start in cycle 0 gives the first `O_rd_en` in cycle 1.
- Sample latency: `O_rd_en` in cycle t, `O_valid_data` in cycle t+2 when there is no hold.
- With no hold and BLOCK_GAP = 0, reads are issued back-to-back: 192·W·H consecutive cycles.
- Per-block overhead is BLOCK_GAP cycles.
- `O_done` comes 2 cycles after the final `O_valid_data` (DRAIN exit, then DONE).
- `O_busy` falls in the cycle after `O_done`.
- Hold release with the skid full: the skid entry is output on the first unheld edge, and issue resumes one cycle later. No sample is lost or duplicated.
- `I_start` while busy has no effect.

## Test plan
- **1x1 block image, no hold, GAP = 0.** Expect 192 reads:
  - addresses 0..63 on plane 0, then plane 1, then plane 2;
  - `O_ycbcr` of 2'b10 x64, 2'b00 x64, 2'b01 x64;
  - `O_end_of_img` on sample 192 only;
  - `O_done` 2 cycles later.
- **W = 2, H = 2.** The second MCU's Y block starts at address 8. Row 1 of MCU (bx=0, by=1) is at address 144. The data stream matches a reference model byte-for-byte.
- **Random `I_hold` (~30%) on a 3x2 image.** No lost or duplicated sample. `O_rd_en` is never high while `I_hold`=1. The skid never overflows.
- **BLOCK_GAP = 4.** Exactly 4 read-free cycles (absent hold) after every block, including the last before DRAIN.
- **Start with W = 0.** `O_done` pulses 1 cycle later and no `O_rd_en` occurs. A start while busy is ignored.
- **`I_rst` pulsed mid-frame.** All outputs are 0 the next cycle, and a new start runs a full clean frame.
